// File: rtl/cb_pkg.sv
// Shared types and helpers for the counting/checkerboard read-back checker:
// state encoding, level-code decoding and expected bit-plane generation.
`ifndef WORD_SIZE
`define WORD_SIZE 48
`endif
`ifndef PROG_CNFG_RANGES_LOG2_N
`define PROG_CNFG_RANGES_LOG2_N 4
`endif

package cb_pkg;

  localparam int WORD_SIZE_D = `WORD_SIZE;
  localparam int NPLANES_D   = `PROG_CNFG_RANGES_LOG2_N;
  localparam int CNT_W_D     = 32;
  localparam int PLANE_VEC_W = NPLANES_D * WORD_SIZE_D;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef logic [NPLANES_D:0] modulus_t;

  // Plane j of a word occupies bits [plane_lo(j) +: WORD_SIZE].
  function automatic int plane_lo(input int j);
    return j * WORD_SIZE_D;
  endfunction

  function automatic modulus_t level_modulus(input logic [NPLANES_D-1:0] code);
    modulus_t l;
    l = modulus_t'(1);
    if (code == '0)                   l = modulus_t'(1) << NPLANES_D;
    else if (code == NPLANES_D'(8))   l = modulus_t'(8);
    else if (code == NPLANES_D'(4))   l = modulus_t'(4);
    else if (code == NPLANES_D'(2))   l = modulus_t'(2);
    return l;
  endfunction

  // Every legal modulus is a power of two, so (n + i) mod L is a mask.
  function automatic logic [PLANE_VEC_W-1:0] expected_planes(
    input logic [CNT_W_D-1:0] n,
    input modulus_t           l
  );
    logic [PLANE_VEC_W-1:0] v;
    logic [CNT_W_D-1:0]     sum;
    modulus_t               mask;
    logic [NPLANES_D-1:0]   lvl;
    v    = '0;
    mask = l - modulus_t'(1);
    for (int i = 0; i < WORD_SIZE_D; i++) begin
      sum = n + CNT_W_D'(i);
      lvl = sum[NPLANES_D-1:0] & mask[NPLANES_D-1:0];
      for (int j = 0; j < NPLANES_D; j++) v[plane_lo(j) + i] = lvl[j];
    end
    return v;
  endfunction

endpackage

// File: rtl/cb_popcount.sv
// Population count of a mismatch vector, registered so it forms the second
// stage of the compare pipeline.
module cb_popcount #(
  parameter  int W  = 48,
  localparam int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] sum;

  // NOTE: always_comb accumulators get a default before the loop so no latch is inferred.
  always_comb begin
    sum = '0;
    for (int i = 0; i < W; i++) sum = sum + CW'(vec[i]);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= sum;
  end

endmodule

// File: rtl/cb_checker.sv
// Read-back checker: regenerates the expected level pattern per accepted word,
// compares it against the bit planes and accumulates saturating error stats.
module cb_checker
  import cb_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_D,
  parameter int NPLANES   = NPLANES_D,
  parameter int CNT_W     = CNT_W_D
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NPLANES-1:0]           num_levels,
  input  logic [CNT_W-1:0]             num_words,
  input  logic                         rd_valid,
  output logic                         rd_ready,
  input  logic [NPLANES*WORD_SIZE-1:0] rd_data,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             word_idx,
  output logic [CNT_W-1:0]             cell_err_cnt,
  output logic [CNT_W-1:0]             word_err_cnt,
  output logic [CNT_W-1:0]             first_err_idx,
  output logic                         first_err_valid
);

  localparam int DW   = NPLANES * WORD_SIZE;
  localparam int PC_W = $clog2(WORD_SIZE + 1);

  state_t              state, state_next;
  logic [NPLANES-1:0]  levels_q;
  logic [CNT_W-1:0]    words_q;
  logic                accept, last_beat, restart;
  logic                s1_valid, s2_valid;
  logic [DW-1:0]       s1_data, s1_exp, diff;
  logic [CNT_W-1:0]    s1_idx, s2_idx;
  logic [WORD_SIZE-1:0] mismatch;
  logic [PC_W-1:0]     pop;
  logic [CNT_W:0]      cell_sum, word_sum;

  assign rd_ready  = (state == RUN);
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign accept    = rd_valid && rd_ready;
  assign last_beat = (word_idx + CNT_W'(1)) == words_q;
  assign restart   = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (start) state_next = (num_words == '0) ? DONE : RUN;
      RUN:        if (accept && last_beat) state_next = DRAIN;
      // Stage 2 retires on the same edge that leaves DRAIN, so only stage 1 matters.
      DRAIN:      if (!s1_valid) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // Stage 1 compare: a cell mismatches if any of its plane bits differ.
  assign diff = s1_data ^ s1_exp;
  always_comb begin
    mismatch = '0;
    for (int i = 0; i < WORD_SIZE; i++)
      for (int j = 0; j < NPLANES; j++) mismatch[i] = mismatch[i] | diff[j*WORD_SIZE + i];
  end

  cb_popcount #(.W(WORD_SIZE)) u_popcount (
    .clk (clk),
    .rst (rst),
    .vec (mismatch),
    .cnt (pop)
  );

  assign cell_sum = {1'b0, cell_err_cnt} + (CNT_W+1)'(pop);
  assign word_sum = {1'b0, word_err_cnt} + (CNT_W+1)'(pop != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      levels_q        <= '0;
      words_q         <= '0;
      word_idx        <= '0;
      cell_err_cnt    <= '0;
      word_err_cnt    <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
      s1_valid        <= 1'b0;
      s2_valid        <= 1'b0;
    end else begin
      state    <= state_next;
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (restart) begin
        levels_q        <= num_levels;
        words_q         <= num_words;
        word_idx        <= '0;
        cell_err_cnt    <= '0;
        word_err_cnt    <= '0;
        first_err_idx   <= '0;
        first_err_valid <= 1'b0;
      end
      if (accept) word_idx <= word_idx + CNT_W'(1);
      if (s2_valid) begin
        cell_err_cnt <= cell_sum[CNT_W] ? '1 : cell_sum[CNT_W-1:0];
        word_err_cnt <= word_sum[CNT_W] ? '1 : word_sum[CNT_W-1:0];
        if ((pop != '0) && !first_err_valid) begin
          first_err_idx   <= s2_idx;
          first_err_valid <= 1'b1;
        end
      end
    end
  end

  // NOTE: pipeline payload registers are qualified by s1_valid/s2_valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_data <= rd_data;
      s1_exp  <= expected_planes(word_idx, level_modulus(levels_q));
      s1_idx  <= word_idx;
    end
    s2_idx <= s1_idx;
  end

endmodule

// File: tb/tb_cb_checker.sv
// Self-checking bench for cb_checker: randomized and directed runs compared
// every cycle against a behavioural scoreboard model.
module tb_cb_checker;

  localparam int WS = 48;
  localparam int NP = 4;
  localparam int DW = WS * NP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NP-1:0] num_levels = '0;
  logic [31:0]   num_words = '0;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic [DW-1:0] rd_data = '0;
  logic          busy, done;
  logic [31:0]   word_idx, cell_err_cnt, word_err_cnt, first_err_idx;
  logic          first_err_valid;

  cb_checker dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .num_levels      (num_levels),
    .num_words       (num_words),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .rd_data         (rd_data),
    .busy            (busy),
    .done            (done),
    .word_idx        (word_idx),
    .cell_err_cnt    (cell_err_cnt),
    .word_err_cnt    (word_err_cnt),
    .first_err_idx   (first_err_idx),
    .first_err_valid (first_err_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned code_to_l(input logic [NP-1:0] code);
    case (code)
      4'd0:    return 16;
      4'd8:    return 8;
      4'd4:    return 4;
      4'd2:    return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [DW-1:0] pattern(input int unsigned n, input int unsigned l);
    logic [DW-1:0] v;
    int unsigned   lvl;
    v = '0;
    for (int i = 0; i < WS; i++) begin
      lvl = (n + i) % l;
      for (int j = 0; j < NP; j++) v[j*WS + i] = lvl[j];
    end
    return v;
  endfunction

  function automatic int count_bad(input logic [DW-1:0] d, input int unsigned n, input int unsigned l);
    int c;
    int unsigned got;
    c = 0;
    for (int i = 0; i < WS; i++) begin
      got = 0;
      for (int j = 0; j < NP; j++) got = got | (int'(d[j*WS + i]) << j);
      if (got != (n + i) % l) c++;
    end
    return c;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic longint unsigned sat(input longint unsigned x);
    return (x > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : x;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    longint      at;
    int          cells;
    int unsigned idx;
  } pend_t;

  pend_t             pend[$];
  longint            cyc = 0;
  bit                m_acc = 0, m_active = 0, m_done = 0, m_ferr_v = 0;
  longint            m_done_at = -1;
  int unsigned       m_widx = 0, m_target = 0, m_l = 1, m_ferr_idx = 0;
  longint unsigned   m_cell = 0, m_word = 0;

  always @(negedge clk) begin
    bit    acc_now, st_now;
    pend_t p;
    check("rd_ready", rd_ready, m_acc);
    check("busy", busy, m_active);
    check("done", done, m_done);
    check("word_idx", word_idx, m_widx);
    check("cell_err_cnt", cell_err_cnt, m_cell);
    check("word_err_cnt", word_err_cnt, m_word);
    check("first_err_valid", first_err_valid, m_ferr_v);
    if (m_ferr_v) check("first_err_idx", first_err_idx, m_ferr_idx);

    if (rst) begin
      pend.delete();
      m_acc = 0; m_active = 0; m_done = 0; m_ferr_v = 0; m_done_at = -1;
      m_widx = 0; m_cell = 0; m_word = 0; m_ferr_idx = 0;
    end else begin
      acc_now = m_acc && rd_valid;
      st_now  = start && !m_active;
      while (pend.size() > 0 && pend[0].at == cyc) begin
        p = pend.pop_front();
        m_cell = sat(m_cell + p.cells);
        if (p.cells > 0) begin
          m_word = sat(m_word + 1);
          if (!m_ferr_v) begin
            m_ferr_v   = 1;
            m_ferr_idx = p.idx;
          end
        end
      end
      if (m_active && !m_acc && m_done_at == cyc) begin
        m_active = 0;
        m_done   = 1;
      end
      if (acc_now) begin
        p.at    = cyc + 2;
        p.cells = count_bad(rd_data, m_widx, m_l);
        p.idx   = m_widx;
        pend.push_back(p);
        m_widx++;
        if (m_widx == m_target) begin
          m_acc     = 0;
          m_done_at = cyc + 2;
        end
      end
      if (st_now) begin
        m_l      = code_to_l(num_levels);
        m_target = num_words;
        m_widx   = 0; m_cell = 0; m_word = 0; m_ferr_v = 0;
        m_done   = (num_words == 0);
        m_active = (num_words != 0);
        m_acc    = (num_words != 0);
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] flips [64];
  int unsigned   cur_l = 1;

  task automatic clear_flips();
    for (int k = 0; k < 64; k++) flips[k] = '0;
  endtask

  task automatic do_start(input logic [NP-1:0] code, input int unsigned nw);
    @(posedge clk); #1;
    start = 1'b1; num_levels = code; num_words = nw; cur_l = code_to_l(code);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // period 0 = random valid, otherwise valid once every `period` cycles.
  task automatic send_words(input int stop_at, input int period, input int mid_start_at);
    int k = 0;
    int budget = 0;
    bit v;
    while (k < stop_at && budget < 2000) begin
      @(posedge clk); #1;
      budget++;
      start = (budget == mid_start_at);
      if (start) begin
        num_words  = 3;
        num_levels = 4'd4;
      end
      v = (period == 0) ? bit'($urandom_range(0, 1)) : (budget % period == 0);
      rd_valid = v;
      rd_data  = v ? (pattern(k, cur_l) ^ flips[k % 64]) : rand_word();
      @(negedge clk);
      if (rd_valid && rd_ready) k++;
    end
    if (budget >= 2000) check("send_timeout", k, stop_at);
    @(posedge clk); #1;
    rd_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_done();
    int b = 0;
    while (!done && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("done_timeout", done, 1);
  endtask

  task automatic run(input logic [NP-1:0] code, input int unsigned nw, input int period);
    do_start(code, nw);
    send_words(nw, period, -1);
    wait_done();
  endtask

  initial begin
    clear_flips();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Exact 16-level pattern, continuous valid.
    run(4'd0, 4, 1);
    check("s1_cell", cell_err_cnt, 0);
    check("s1_word", word_err_cnt, 0);
    check("s1_ferr_v", first_err_valid, 0);
    check("s1_idx", word_idx, 4);

    // Data offered while not ready must be ignored.
    @(posedge clk); #1;
    rd_valid = 1'b1; rd_data = rand_word();
    @(posedge clk); #1;
    rd_valid = 1'b0;
    @(negedge clk);
    check("idle_ignore_idx", word_idx, 4);

    // L=4 with three flipped cells in two words.
    flips[3][5]      = 1'b1;
    flips[6][WS + 0] = 1'b1;
    flips[6][WS + 1] = 1'b1;
    run(4'd4, 8, 1);
    check("s2_cell", cell_err_cnt, 3);
    check("s2_word", word_err_cnt, 2);
    check("s2_ferr_idx", first_err_idx, 3);
    check("s2_ferr_v", first_err_valid, 1);
    clear_flips();

    // Sparse valid, same results as the first run.
    run(4'd0, 4, 3);
    check("s3_cell", cell_err_cnt, 0);
    check("s3_idx", word_idx, 4);

    // Code 3 decodes to L=1: expected level always 0.
    run(4'd3, 2, 1);
    check("s4a_cell", cell_err_cnt, 0);
    flips[1][3*WS +: WS] = '1;
    run(4'd3, 2, 1);
    check("s4b_cell", cell_err_cnt, 48);
    check("s4b_word", word_err_cnt, 1);
    check("s4b_ferr_idx", first_err_idx, 1);
    clear_flips();

    // Reset mid-run after two accepts.
    flips[0][0] = 1'b1;
    do_start(4'd8, 8);
    send_words(2, 1, -1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", rd_ready, 0);
    check("rst_idx", word_idx, 0);
    check("rst_cell", cell_err_cnt, 0);
    check("rst_ferr_v", first_err_valid, 0);
    clear_flips();
    flips[2][WS*2 + 7] = 1'b1;
    run(4'd8, 8, 1);
    check("rst_rerun_cell", cell_err_cnt, 1);
    check("rst_rerun_ferr_idx", first_err_idx, 2);
    clear_flips();

    // Zero-length run, then a start pulse mid-run that must be ignored.
    do_start(4'd2, 0);
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_cell", cell_err_cnt, 0);
    do_start(4'd2, 6);
    send_words(6, 1, 3);
    wait_done();
    check("midstart_idx", word_idx, 6);

    // Randomized runs.
    for (int r = 0; r < 10; r++) begin
      int unsigned nw;
      logic [NP-1:0] code;
      code = NP'($urandom_range(0, 15));
      if (r % 2 == 0) code = (r % 4 == 0) ? 4'd0 : 4'd8;
      nw = $urandom_range(1, 24);
      clear_flips();
      for (int k = 0; k < 24; k++)
        if ($urandom_range(0, 3) == 0) begin
          flips[k][$urandom_range(0, DW - 1)] = 1'b1;
          flips[k][$urandom_range(0, DW - 1)] = 1'b1;
        end
      run(code, nw, (r % 3 == 0) ? 1 : 0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
